// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the nibble FIFO and its UART drain.
// The master modport is the consumer that issues read strobes.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the nibble FIFO, pairs nibbles low-first into bytes and
// transmits each byte as UART 8N1 at CLK_DIV clocks per bit.
module fifo_uart_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CAP_LO, WAIT_HI, CAP_HI, START, DATA, STOP
  } state_t;

  state_t        state, state_next;
  logic [3:0]    lo, lo_next;
  logic [7:0]    shift, shift_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic          tx_next;
  logic          pop;
  logic          bit_done;

  // Gated by reset so no read can reach the FIFO while we are held in reset
  assign pop          = reset && (state == IDLE || state == WAIT_HI) && !fifo.fifo_empty;
  assign fifo.fifo_rd = pop;
  assign bit_done     = (baud_cnt == BIT_LAST);
  assign busy         = (state != IDLE);

  always_comb begin
    state_next = state;
    lo_next    = lo;
    shift_next = shift;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    case (state)
      IDLE:    if (pop) state_next = CAP_LO;
      CAP_LO:  begin
        lo_next    = fifo.fifo_data;
        state_next = WAIT_HI;
      end
      WAIT_HI: if (pop) state_next = CAP_HI;
      CAP_HI:  begin
        shift_next = {fifo.fifo_data, lo};
        baud_next  = '0;
        state_next = START;
      end
      START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) state_next = STOP;
          else                 bit_next   = bit_cnt + 3'd1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from where we are going, so tx is glitch-free and aligned to bit edges
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lo       <= '0;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      lo       <= lo_next;
      shift    <= shift_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Drives a queue-based FIFO model into fifo_uart_tx and decodes the serial
// line with a frame monitor that scores each byte against expected bytes.
module tb_fifo_uart_tx;
  localparam int D     = 4;
  localparam int FRAME = 10 * D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;

  fifo_uart_tx_if bus ();

  fifo_uart_tx #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus.master),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] pend_q[$];
  logic [3:0] mem_q[$];
  logic [7:0] exp_q[$];
  int         start_cycles[$];
  int         cyc = 0;
  int         last_rd = -100;
  bit         active = 0;
  int         pos = 0;
  logic       samples[FRAME];

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] nib);
    pend_q.push_back(nib);
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(b[3:0]);
    applyStimulus(b[7:4]);
    exp_q.push_back(b);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || active || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", int'(n < budget), 1);
  endtask

  task automatic decodeFrame();
    logic [7:0] got;
    bit shape_ok = 1'b1;
    for (int b = 0; b < 10; b++)
      for (int s = 1; s < D; s++)
        if (samples[b*D+s] !== samples[b*D]) shape_ok = 1'b0;
    for (int k = 0; k < 8; k++) got[k] = samples[(k+1)*D];
    checkOutput("bit_shape", int'(shape_ok), 1);
    checkOutput("stop_bit", int'(samples[9*D]), 1);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_frame: got %0h, expected no frame", got);
    end else begin
      checkOutput("frame_byte", int'(got), int'(exp_q.pop_front()));
    end
  endtask

  // FIFO model: registered read data and an empty flag that updates after each edge
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      checkOutput("rd_while_empty", int'(mem_q.size() == 0), 0);
      if (mem_q.size() != 0) bus.fifo_data <= mem_q.pop_front();
    end
    while (pend_q.size() != 0) mem_q.push_back(pend_q.pop_front());
    bus.fifo_empty <= (mem_q.size() == 0);
  end

  // Line monitor: collects one sample per cycle across a whole frame
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      checkOutput("reset_outputs", int'({tx, busy, bus.fifo_rd}), 3'b100);
      active = 1'b0;
    end else begin
      if (bus.fifo_rd) last_rd = cyc;
      if (!active && tx == 1'b0) begin
        active = 1'b1;
        pos    = 0;
        start_cycles.push_back(cyc);
        checkOutput("start_latency", cyc - last_rd, 2);
      end
      if (active) begin
        samples[pos] = tx;
        pos++;
        if (pos == FRAME) begin
          active = 1'b0;
          decodeFrame();
        end
      end
    end
  end

  initial begin
    int n0;
    int n;
    int bad;
    logic [7:0] rb;

    #1 reset = 1'b0;
    pushByte(8'hA5);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rd_after_reset", int'(bus.fifo_rd), 1);
    @(negedge clk);
    checkOutput("busy_rise", int'(busy), 1);
    waitDrain(200);

    // Odd nibble parks the block in WAIT_HI
    applyStimulus(4'h3);
    repeat (3) @(negedge clk);
    repeat (50) begin
      @(negedge clk);
      checkOutput("wait_hi_hold", int'({tx, busy}), 2'b11);
    end
    applyStimulus(4'hC);
    exp_q.push_back(8'hC3);
    waitDrain(200);

    n0 = start_cycles.size();
    pushByte(8'h21);
    pushByte(8'h43);
    waitDrain(300);
    checkOutput("b2b_frames", start_cycles.size() - n0, 2);
    if (start_cycles.size() >= n0 + 2)
      checkOutput("b2b_gap", start_cycles[n0+1] - start_cycles[n0], FRAME + 4);

    // Abort 0xA5 during data bit 3
    n0 = start_cycles.size();
    applyStimulus(4'h5);
    applyStimulus(4'hA);
    n = 0;
    while (start_cycles.size() == n0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("abort_frame_started", start_cycles.size() - n0, 1);
    repeat (17) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_tx_high", int'({tx, busy}), 2'b10);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle", int'({tx, busy, bus.fifo_rd}), 3'b100);
    pushByte(8'h96);
    waitDrain(200);

    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.fifo_rd || busy || !tx) bad++;
    end
    checkOutput("empty_hold_bad_cycles", bad, 0);

    repeat (20) begin
      rb = 8'($urandom);
      applyStimulus(rb[3:0]);
      repeat ($urandom_range(0, 60)) @(negedge clk);
      applyStimulus(rb[7:4]);
      exp_q.push_back(rb);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    waitDrain(3000);
    checkOutput("exp_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer of the 4-bit block-RAM FIFO. It pops nibbles through the FIFO's `rd`/`empty`/`r_data` port and pairs two consecutive nibbles into one byte, low nibble first. It then transmits each byte on a UART 8N1 serial line at a rate set by a clock divider. This is the FIFO drain path to the board's serial port.

## Interface
Parameters:
- `CLK_DIV`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2 or greater.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_data`  input  4  FIFO `r_data`. Valid in the cycle after `fifo_rd` is high (synchronous BRAM read).
- `fifo_rd`  output  1  FIFO read strobe, one cycle per nibble.
- `tx`  output  1  serial line, idle high, registered.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no data held.
  - CAP_LO: capture the low nibble.
  - WAIT_HI: wait for and pop the high nibble.
  - CAP_HI: capture the high nibble.
  - START: send the start bit.
  - DATA: send 8 data bits.
  - STOP: send the stop bit.
- `fifo_rd` is combinational: `fifo_rd = (state==IDLE || state==WAIT_HI) && !fifo_empty`. It is never high while `fifo_empty` is high.
- Transitions:
  - IDLE to CAP_LO when `fifo_rd` fires.
  - CAP_LO: `lo <= fifo_data`, then go to WAIT_HI.
  - WAIT_HI to CAP_HI when `fifo_rd` fires. Otherwise stay in WAIT_HI indefinitely, holding `lo`.
  - CAP_HI: `shift <= {fifo_data, lo}`, then go to START.
  - START lasts CLK_DIV cycles, then go to DATA.
  - DATA sends 8 bits LSB first, CLK_DIV cycles each, from a 3-bit bit counter. After bit 7, go to STOP.
  - STOP lasts CLK_DIV cycles, then go to IDLE.
- Baud counter: width `$clog2(CLK_DIV)`. Cleared on entry to START, DATA and STOP and at each bit boundary. A bit ends when the counter equals CLK_DIV-1.
- `tx` value by state:
  - 0 in START.
  - `shift[bitcnt]` in DATA.
  - 1 in STOP, IDLE, CAP_LO, WAIT_HI and CAP_HI.
- `tx` is registered from the next-state and next-bit values, so the line changes exactly on state and bit boundaries.
- Reset (`reset`=0, any time, including mid-frame):
  - state goes to IDLE.
  - `tx`=1, `fifo_rd`=0 (since `fifo_empty` is irrelevant while in reset), `busy`=0.
  - `lo`, `shift`, the baud counter and the bit counter are cleared.
  - A held low nibble or a partly sent byte is discarded, not retransmitted.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd`=0.
- Let cycle 0 be the IDLE cycle with `fifo_rd`=1, with the FIFO holding at least 2 nibbles:
  - Cycle 1 is CAP_LO.
  - Cycle 2 is WAIT_HI with `fifo_rd`=1.
  - Cycle 3 is CAP_HI.
  - `tx` falls at cycle 4.
- Frame length is exactly 10×CLK_DIV cycles:
  - start bit: cycles 4 to 4+CLK_DIV-1.
  - data bit k: starts at cycle 4+(k+1)×CLK_DIV.
  - stop bit ends at 4+10×CLK_DIV-1.
- `busy` rises in cycle 1 and falls on the cycle IDLE is re-entered.
- Back-to-back bytes: IDLE can pop on its first cycle. The idle-high gap between consecutive stop and start bits is therefore exactly 4 cycles.
- At most one `fifo_rd` per pop state. Two `fifo_rd` pulses are always at least 2 cycles apart, so the FIFO's `empty` update is always seen before the next read decision.
- Odd nibble count: the block stays in WAIT_HI with `tx`=1 and `busy`=1 until another nibble arrives.

## Test plan
- Reset: hold `reset`=0 with `fifo_empty`=0 → `tx`=1, `busy`=0, `fifo_rd`=0 throughout; after release, the first `fifo_rd` fires the next cycle.
- Single byte, CLK_DIV=4, FIFO nibbles 0x5 then 0xA → byte 0xA5.
  - `tx` sequence per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - `tx` falls at cycle 4 after the first `fifo_rd`; frame is 40 cycles.
- Lone nibble 0x3, then 0xC pushed 50 cycles later:
  - `tx` stays 1 and `busy` stays 1 in WAIT_HI during the wait.
  - The frame carries 0xC3 and starts 2 cycles after the second `fifo_rd`.
- Back-to-back: nibbles 1,2,3,4 with CLK_DIV=4 → bytes 0x21 then 0x43; exactly 4 cycles of `tx`=1 between the first stop bit and the second start bit.
- `reset` pulsed low during data bit 3 of 0xA5:
  - `tx`=1 immediately, state IDLE, byte discarded.
  - With the FIFO then holding 0x6,0x9, the next frame is a clean 0x96.
- `fifo_empty` held high for 1000 cycles after reset → `fifo_rd` never asserts; `busy`=0; `tx`=1.
